crypto_dispatch: RTL and testbench
==================================

// Module: crypto_dispatch
// PURPOSE
// - Command front-end placed directly upstream of the crypto core. It queues encrypt/decrypt requests from the processor bus.
// - Each request is run on the core in turn: reset pulse, held begin strobe, wait for fin. It then captures the data and key outputs.
// - Results go back to the processor over a valid/ready response port; one operation is in flight at a time.
// PARAMETERS
// DEPTH        4   request FIFO entries; power of 2, >=2
// RST_CYCLES   2   cycles core_rst held low before each operation (>=1)
// BGN_CYCLES   10  cycles core_bgn held high per operation (>=1)
// TIMEOUT      255 max cycles in WAIT before abort (only with CRYPTO_TIMEOUT_EN)
// PORTS
// clk            in   1   clock, all logic on posedge
// rst            in   1   asynchronous, active-low reset
// req_valid      in   1   request present
// req_ready      out  1   FIFO can accept (= !full)
// req_op         in   2   01 encrypt, 10 decrypt, 00/11 illegal
// req_data       in   16  data word
// req_key        in   16  key word
// rsp_valid      out  1   result present
// rsp_ready      in   1   processor takes result
// rsp_data       out  16  result data
// rsp_key        out  16  result key (round key out of core)
// rsp_err        out  1   1 = illegal op or timeout
// core_rst       out  1   active-low reset to crypto core
// core_bgn       out  1   begin strobe to crypto core
// core_mode      out  2   cript_or_decript to crypto core
// core_data      out  16  data_inbus to crypto core
// core_key       out  16  key_inbus to crypto core
// core_fin       in   1   fin from crypto core
// core_data_out  in   16  data_outbus from crypto core
// core_key_out   in   16  key_outbus from crypto core
// busy           out  1   FSM not IDLE or FIFO not empty
// fifo_count     out  $clog2(DEPTH)+1  entries queued
// BEHAVIOUR
// - Reset (rst=0, async): FIFO emptied, FSM=IDLE, rsp_valid=0, rsp_data/rsp_key=0, rsp_err=0, core_rst=0, core_bgn=0,
//   core_mode=00, core_data/core_key=0, busy=0, fifo_count=0. core_rst goes 1 on first posedge after release.
// - FIFO: entry = {op,data,key}, 34 bits. Push on req_valid&&req_ready; no push when full, even with a same-cycle pop.
//   Pop only by FSM in IDLE. Pointers wrap mod DEPTH; fifo_count exact, including simultaneous push+pop.
// - FSM states and transitions:
//   IDLE: if FIFO non-empty and rsp_valid==0, pop head into op/data/key registers.
//         Legal op -> CLR. Illegal op -> RESP with rsp_err=1, rsp_data=rsp_key=0; core untouched.
//   CLR: core_rst=0 for RST_CYCLES cycles; core_mode/core_data/core_key driven from the popped entry; -> START.
//   START: core_rst=1, core_bgn=1 for BGN_CYCLES cycles; -> WAIT.
//   WAIT: core_bgn=0; on core_fin==1 -> CAPTURE.
//   CAPTURE: one cycle; latch core_data_out/core_key_out into rsp_data/rsp_key, rsp_err=0; -> RESP.
//   RESP: rsp_valid=1; fields stable until rsp_valid&&rsp_ready; then rsp_valid=0 -> IDLE.
// - core_mode/core_data/core_key stay stable from CLR through CAPTURE; they return to 00/0/0 in IDLE.
// - Latency for an empty, idle block: accept edge -> IDLE pop +1 -> RST_CYCLES+BGN_CYCLES -> core time -> +1 CAPTURE -> rsp_valid.
// - A fin already high on entry to WAIT counts as completion. Fin outside WAIT is ignored.
// - Requests keep being accepted during an operation until the FIFO is full.
// CONFIGURATION
// - CRYPTO_TIMEOUT_EN defined: an 8+ bit counter runs in WAIT.
//   If it reaches TIMEOUT without fin: core_rst=0 for one cycle, rsp_err=1, rsp_data=rsp_key=0, then -> RESP.
// - Macro undefined: no counter, WAIT exits only on fin, rsp_err flags illegal ops only.
// TESTING (core replaced by a stub: fin N cycles after bgn falls; data_out=data^16'hFFFF, key_out=key+1)
// - Encrypt 59B3/1325, N=5 -> one CLR+START sequence, core_mode=01; rsp_data=A64C, rsp_key=1326, rsp_err=0.
// - Back-to-back pushes of 36CB/A058 (op 10) and 5CFE/83E6 (op 01), rsp_ready=1 -> rsp C934/A059 then A301/83E7, in order.
// - Push DEPTH+1 requests with rsp_ready=0 -> req_ready=0 at fifo_count=DEPTH; extra request stalls; nothing lost after drain.
// - req_op=11 -> rsp_err=1 and data/key 0; core_rst and core_bgn never pulse.
// - rst low during WAIT -> all outputs at reset values at once; FIFO empty; a new request afterwards completes normally.
// - CRYPTO_TIMEOUT_EN, stub never asserts fin, TIMEOUT=20 -> rsp_err=1 after 20 WAIT cycles; without the macro, busy stays 1.

Source files
------------

// File: rtl/crypto_dispatch.sv
// Command front-end for the crypto core: queues encrypt/decrypt requests, runs them one at a time, returns results.
// Optional WAIT-state timeout abort is enabled by defining CRYPTO_TIMEOUT_EN.
module crypto_dispatch #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned BGN_CYCLES = 10,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [15:0]                req_data,
    input  logic [15:0]                req_key,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [15:0]                rsp_data,
    output logic [15:0]                rsp_key,
    output logic                       rsp_err,
    output logic                       core_rst,
    output logic                       core_bgn,
    output logic [1:0]                 core_mode,
    output logic [15:0]                core_data,
    output logic [15:0]                core_key,
    input  logic                       core_fin,
    input  logic [15:0]                core_data_out,
    input  logic [15:0]                core_key_out,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned M1  = (RST_CYCLES > BGN_CYCLES) ? RST_CYCLES : BGN_CYCLES;
    localparam int unsigned M2  = (M1 > TIMEOUT) ? M1 : TIMEOUT;
    localparam int unsigned TW0 = $clog2(M2 + 1);
    localparam int unsigned TW  = (TW0 < 8) ? 8 : TW0;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] key;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_START, S_WAIT, S_CAPTURE, S_RESP, S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            req_ready_q, busy_q;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d, rsp_key_q, rsp_key_d;
    logic            rsp_err_q, rsp_err_d;
    logic            core_rst_q, core_rst_d, core_bgn_q, core_bgn_d;
    logic [1:0]      core_mode_q, core_mode_d;
    logic [15:0]     core_data_q, core_data_d, core_key_q, core_key_d;
    logic            push, pop, full, empty;
    req_t            head;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = req_valid && !full;
    assign head    = mem_q[rd_ptr_q];
    assign count_d = count_q + CW'(push) - CW'(pop);

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: req_op, data: req_data, key: req_key};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_key_q   <= '0;
            rsp_err_q   <= 1'b0;
            core_rst_q  <= 1'b0;
            core_bgn_q  <= 1'b0;
            core_mode_q <= '0;
            core_data_q <= '0;
            core_key_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            req_ready_q <= (count_d != CW'(DEPTH));
            busy_q      <= (state_d != S_IDLE) || (count_d != '0);
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_key_q   <= rsp_key_d;
            rsp_err_q   <= rsp_err_d;
            core_rst_q  <= core_rst_d;
            core_bgn_q  <= core_bgn_d;
            core_mode_q <= core_mode_d;
            core_data_q <= core_data_d;
            core_key_q  <= core_key_d;
        end
    end

    // Next-state logic; core strobes are computed for the state being entered so they align with state_q.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_key_d   = rsp_key_q;
        rsp_err_d   = rsp_err_q;
        core_rst_d  = 1'b1;
        core_bgn_d  = 1'b0;
        core_mode_d = core_mode_q;
        core_data_d = core_data_q;
        core_key_d  = core_key_q;
        case (state_q)
            S_IDLE: begin
                core_mode_d = '0;
                core_data_d = '0;
                core_key_d  = '0;
                if (!empty && !rsp_valid_q) begin
                    pop = 1'b1;
                    if (head.op == 2'b01 || head.op == 2'b10) begin
                        state_d     = S_CLR;
                        cnt_d       = '0;
                        core_rst_d  = 1'b0;
                        core_mode_d = head.op;
                        core_data_d = head.data;
                        core_key_d  = head.key;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_key_d   = '0;
                    end
                end
            end
            S_CLR: begin
                core_rst_d = 1'b0;
                if (cnt_q == TW'(RST_CYCLES - 1)) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    core_bgn_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_START: begin
                core_bgn_d = 1'b1;
                if (cnt_q == TW'(BGN_CYCLES - 1)) begin
                    state_d    = S_WAIT;
                    cnt_d      = '0;
                    core_bgn_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT: begin
                if (core_fin) begin
                    state_d = S_CAPTURE;
                end
`ifdef CRYPTO_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d    = S_ABORT;
                    core_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
`endif
            end
            S_CAPTURE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = core_data_out;
                rsp_key_d   = core_key_out;
                rsp_err_d   = 1'b0;
                core_mode_d = '0;
                core_data_d = '0;
                core_key_d  = '0;
            end
            S_ABORT: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_key_d   = '0;
                rsp_err_d   = 1'b1;
                core_mode_d = '0;
                core_data_d = '0;
                core_key_d  = '0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_key    = rsp_key_q;
    assign rsp_err    = rsp_err_q;
    assign core_rst   = core_rst_q;
    assign core_bgn   = core_bgn_q;
    assign core_mode  = core_mode_q;
    assign core_data  = core_data_q;
    assign core_key   = core_key_q;

endmodule

// File: tb/tb_crypto_dispatch.sv
// Directed bench for crypto_dispatch with a stub core: fin FIN_N cycles after bgn falls, data^FFFF, key+1.
// Timeout expectations follow CRYPTO_TIMEOUT_EN.
module tb_crypto_dispatch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RST_C = 2;
    localparam int unsigned BGN_C = 10;
    localparam int unsigned TMO   = 20;
    localparam int unsigned FIN_N = 5;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data, req_key;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data, rsp_key;
    logic        core_rst, core_bgn, core_fin;
    logic [1:0]  core_mode;
    logic [15:0] core_data, core_key, core_data_out, core_key_out;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    crypto_dispatch #(
        .DEPTH(DEPTH), .RST_CYCLES(RST_C), .BGN_CYCLES(BGN_C), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_key(rsp_key), .rsp_err(rsp_err),
        .core_rst(core_rst), .core_bgn(core_bgn), .core_mode(core_mode),
        .core_data(core_data), .core_key(core_key), .core_fin(core_fin),
        .core_data_out(core_data_out), .core_key_out(core_key_out),
        .busy(busy), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core
    logic [7:0] since;
    logic       armed, fin_en;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !core_rst) begin
            since <= 8'd0;
            armed <= 1'b0;
        end else if (core_bgn) begin
            since <= 8'd0;
            armed <= 1'b1;
        end else if (armed && since != 8'(FIN_N)) begin
            since <= since + 8'd1;
        end
    end
    assign core_fin      = fin_en && armed && (since == 8'(FIN_N));
    assign core_data_out = core_data ^ 16'hFFFF;
    assign core_key_out  = core_key + 16'd1;

    // Strobe activity monitor
    int rst_lo_n = 0;
    int bgn_hi_n = 0;
    logic [1:0] last_mode = 2'b00;
    always @(negedge clk) begin
        if (rst_n && !core_rst) rst_lo_n++;
        if (core_bgn) begin
            bgn_hi_n++;
            last_mode = core_mode;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] d, input logic [15:0] k);
        int n;
        req_op = op; req_data = d; req_key = k; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [15:0] ed, input logic [15:0] ek, input logic ee);
        int n;
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(ed));
        chk({tag, "_key"},   32'(rsp_key),   32'(ek));
        chk({tag, "_err"},   32'(rsp_err),   32'(ee));
        @(negedge clk);
    endtask

    task automatic wait_bgn_fall();
        int n;
        n = 0;
        while (!core_bgn && n < 200) begin @(negedge clk); n++; end
        while (core_bgn && n < 200) begin @(negedge clk); n++; end
        chk("bgn_fall_seen", 32'(n < 200), 32'd1);
    endtask

    logic [1:0]  ov_op [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] ov_d  [6] = '{16'h0001, 16'h1234, 16'hF0F0, 16'h0000, 16'hAAAA, 16'h8001};
    logic [15:0] ov_k  [6] = '{16'h0010, 16'h00FF, 16'hFFFF, 16'h7FFF, 16'h5555, 16'hABCD};
    logic [15:0] ov_ed [6] = '{16'hFFFE, 16'hEDCB, 16'h0F0F, 16'hFFFF, 16'h5555, 16'h7FFE};
    logic [15:0] ov_ek [6] = '{16'h0011, 16'h0100, 16'h0000, 16'h8000, 16'h5556, 16'hABCE};

    initial begin
        int b_rst, b_bgn, got, n;
        logic drop;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = '0; req_key = '0;
        rsp_ready = 1'b0; fin_en = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_core_rst",   32'(core_rst),   32'd0);
        chk("rst_core_bgn",   32'(core_bgn),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_rsp_data",   32'(rsp_data),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_core_rst",   32'(core_rst),   32'd1);

        // Single encrypt
        b_rst = rst_lo_n; b_bgn = bgn_hi_n;
        push(2'b01, 16'h59B3, 16'h1325);
        rsp_ready = 1'b1;
        get_rsp("enc1", 16'hA64C, 16'h1326, 1'b0);
        chk("enc1_rst_len", 32'(rst_lo_n - b_rst), 32'(RST_C));
        chk("enc1_bgn_len", 32'(bgn_hi_n - b_bgn), 32'(BGN_C));
        chk("enc1_mode",    32'(last_mode),        32'd1);
        chk("enc1_idle_mode", 32'(core_mode),      32'd0);

        // Back-to-back decrypt then encrypt
        push(2'b10, 16'h36CB, 16'hA058);
        push(2'b01, 16'h5CFE, 16'h83E6);
        get_rsp("b2b0", 16'hC934, 16'hA059, 1'b0);
        get_rsp("b2b1", 16'hA301, 16'h83E7, 1'b0);

        // Overflow: one in flight plus DEPTH queued, then a stalled extra request
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(ov_op[i], ov_d[i], ov_k[i]);
        chk("ovf_count_full", 32'(fifo_count), 32'(DEPTH));
        chk("ovf_ready_low",  32'(req_ready),  32'd0);
        chk("ovf_busy",       32'(busy),       32'd1);
        req_op = ov_op[5]; req_data = ov_d[5]; req_key = ov_k[5]; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("ovf_stall_count", 32'(fifo_count), 32'(DEPTH));
        end
        rsp_ready = 1'b1;
        got = 0; n = 0; drop = 1'b0;
        while (got < 6 && n < 2000) begin
            if (drop) begin
                req_valid = 1'b0;
                drop = 1'b0;
            end else if (req_valid && req_ready) begin
                drop = 1'b1;
            end
            if (rsp_valid) begin
                chk("ovf_rsp_data", 32'(rsp_data), 32'(ov_ed[got]));
                chk("ovf_rsp_key",  32'(rsp_key),  32'(ov_ek[got]));
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("ovf_rsp_total",   32'(got),       32'd6);
        chk("ovf_extra_taken", 32'(req_valid), 32'd0);
        chk("ovf_drained",     32'(fifo_count), 32'd0);

        // Illegal ops never touch the core
        b_rst = rst_lo_n; b_bgn = bgn_hi_n;
        push(2'b11, 16'h1234, 16'h5678);
        get_rsp("ill11", 16'h0000, 16'h0000, 1'b1);
        push(2'b00, 16'hFFFF, 16'hFFFF);
        get_rsp("ill00", 16'h0000, 16'h0000, 1'b1);
        chk("ill_no_rst_pulse", 32'(rst_lo_n - b_rst), 32'd0);
        chk("ill_no_bgn_pulse", 32'(bgn_hi_n - b_bgn), 32'd0);

        // Asynchronous reset while waiting on the core
        fin_en = 1'b0;
        push(2'b01, 16'h1111, 16'h2222);
        push(2'b10, 16'h3333, 16'h4444);
        wait_bgn_fall();
        repeat (3) @(negedge clk);
        chk("wait_count", 32'(fifo_count), 32'd1);
        chk("wait_busy",  32'(busy),       32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("arst_core_rst",  32'(core_rst),   32'd0);
        chk("arst_core_bgn",  32'(core_bgn),   32'd0);
        chk("arst_core_mode", 32'(core_mode),  32'd0);
        chk("arst_core_data", 32'(core_data),  32'd0);
        chk("arst_core_key",  32'(core_key),   32'd0);
        chk("arst_busy",      32'(busy),       32'd0);
        chk("arst_count",     32'(fifo_count), 32'd0);
        chk("arst_rsp_err",   32'(rsp_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1; fin_en = 1'b1;
        @(negedge clk);
        push(2'b10, 16'h4321, 16'h0FF0);
        get_rsp("post_rst", 16'hBCDE, 16'h0FF1, 1'b0);
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Core never finishes
        fin_en = 1'b0;
        push(2'b01, 16'h0F0F, 16'h0001);
        wait_bgn_fall();
`ifdef CRYPTO_TIMEOUT_EN
        b_rst = rst_lo_n;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk("tmo_min_wait", 32'(n >= int'(TMO)), 32'd1);
        chk("tmo_abort_rst", 32'(rst_lo_n - b_rst), 32'd1);
        get_rsp("tmo", 16'h0000, 16'h0000, 1'b1);
`else
        repeat (60) @(negedge clk);
        chk("notmo_busy",      32'(busy),      32'd1);
        chk("notmo_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        fin_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
